// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared 640x480@60 scan timing constants and small helpers
//                used by the scan generator and the level modules.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Pixel coordinate width
    localparam int pA    = 12;

    // Horizontal timing, in pixels
    localparam int H_VIS = 640;
    localparam int H_FP  = 16;
    localparam int H_SYN = 96;
    localparam int H_BP  = 48;

    // Vertical timing, in lines
    localparam int V_VIS = 480;
    localparam int V_FP  = 10;
    localparam int V_SYN = 2;
    localparam int V_BP  = 33;

    // Derived totals
    localparam int H_TOT = H_VIS + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYN + V_BP;

    // True when lo <= val < hi
    function automatic logic in_window(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scan_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen_if
//  Description : Scan output bundle: pixel position, visibility, syncs and
//                the once-per-frame strobe with its frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_scan_gen_if #(
    parameter int pA = vga_pkg::pA
);
    logic [pA-1:0] pix_x;
    logic [pA-1:0] pix_y;
    logic          pix_v;
    logic          hsync;
    logic          vsync;
    logic          imgReturn;
    logic [7:0]    frame_cnt;

    modport master (
        output pix_x, pix_y, pix_v, hsync, vsync, imgReturn, frame_cnt
    );

    modport slave (
        input  pix_x, pix_y, pix_v, hsync, vsync, imgReturn, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pix_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : pix_tick_div
//  Description : Divides the system clock down to a one-cycle pixel tick,
//                high when the divider sits at CLK_DIV-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  wire  clk,
    input  wire  rst,
    output logic pt
);

    generate
        if (CLK_DIV <= 1) begin : g_div_bypass
            // Every clock is a pixel; clk/rst only feed the tie-off
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign pt       = 1'b1;
        end else begin : g_div_count
            localparam int             c_W    = $clog2(CLK_DIV);
            localparam logic [c_W-1:0] c_LAST = c_W'(CLK_DIV - 1);

            logic [c_W-1:0] r_div;

            // Divider counts 0..CLK_DIV-1 and wraps
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_div <= '0;
                end else if (r_div == c_LAST) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign pt = (r_div == c_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen
//  Description : VGA pixel-scan timing generator. Runs the horizontal and
//                vertical scan counters on the pixel tick and registers the
//                decoded position, visibility, active-low syncs and the
//                start-of-vertical-blank strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_gen #(
    parameter int pA      = vga_pkg::pA,
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYN   = vga_pkg::H_SYN,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYN   = vga_pkg::V_SYN,
    parameter int V_BP    = vga_pkg::V_BP
) (
    input  wire            clk,
    input  wire            rst,
    vga_scan_gen_if.master vga
);
    import vga_pkg::*;

    localparam int c_H_TOT    = H_VIS + H_FP + H_SYN + H_BP;
    localparam int c_V_TOT    = V_VIS + V_FP + V_SYN + V_BP;
    localparam int c_HS_START = H_VIS + H_FP;
    localparam int c_HS_END   = c_HS_START + H_SYN;
    localparam int c_VS_START = V_VIS + V_FP;
    localparam int c_VS_END   = c_VS_START + V_SYN;

    localparam logic [pA-1:0] c_H_LAST  = pA'(c_H_TOT - 1);
    localparam logic [pA-1:0] c_V_LAST  = pA'(c_V_TOT - 1);
    localparam logic [pA-1:0] c_V_BLANK = pA'(V_VIS);

    // Both totals must be representable in the coordinate width
    generate
        if ((c_H_TOT > (1 << pA)) || (c_V_TOT > (1 << pA))) begin : g_size_check
            $error("vga_scan_gen: scan totals do not fit in pA bits");
        end
    endgenerate

    logic          w_pt;
    logic [pA-1:0] r_h;
    logic [pA-1:0] r_v;
    logic          r_pt_d;
    logic          w_vis;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_frame_start;

    logic [pA-1:0] r_pix_x;
    logic [pA-1:0] r_pix_y;
    logic          r_pix_v;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_img_return;
    logic [7:0]    r_frame_cnt;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_div (
        .clk (clk),
        .rst (rst),
        .pt  (w_pt)
    );

    // Scan counters: h wraps each line, v steps on the h wrap; the frame
    // corner returns to (0,0) in one step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pt) begin
            if (r_h == c_H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Remembers that the counters moved on the last edge, so the
    // start-of-blank strobe fires only in the first clock of that pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pt_d <= 1'b0;
        end else begin
            r_pt_d <= w_pt;
        end
    end

    assign w_vis         = in_window(int'(r_h), 0, H_VIS) && in_window(int'(r_v), 0, V_VIS);
    assign w_hs_act      = in_window(int'(r_h), c_HS_START, c_HS_END);
    assign w_vs_act      = in_window(int'(r_v), c_VS_START, c_VS_END);
    assign w_frame_start = r_pt_d && (r_h == '0) && (r_v == c_V_BLANK);

    // Output decode register; syncs idle high, frame counter steps with the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_v      <= 1'b0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_img_return <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_pix_x      <= r_h;
            r_pix_y      <= r_v;
            r_pix_v      <= w_vis;
            r_hsync      <= ~w_hs_act;
            r_vsync      <= ~w_vs_act;
            r_img_return <= w_frame_start;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign vga.pix_x     = r_pix_x;
    assign vga.pix_y     = r_pix_y;
    assign vga.pix_v     = r_pix_v;
    assign vga.hsync     = r_hsync;
    assign vga.vsync     = r_vsync;
    assign vga.imgReturn = r_img_return;
    assign vga.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_gen
//  Description : Self-checking bench for vga_scan_gen. Two instances with a
//                reduced raster (14x8 pixels, 8x4 visible): one at CLK_DIV=2
//                and one at CLK_DIV=1. Every clock is compared against a
//                closed-form position model via a scoreboard queue, plus a
//                hand-computed vector table and measured periods/widths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 1;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;   // 14
    localparam int VT = VV + VF + VS + VB;   // 8

    localparam int F_HS = 0, F_VS = 1, F_IR = 2, F_PV = 3;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        pv;
        logic        hs;
        logic        vs;
        logic        ir;
        logic [7:0]  fc;
    } outs_t;

    typedef struct {
        int    t;
        outs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    vga_scan_gen_if #(.pA(12)) bus1 ();
    vga_scan_gen_if #(.pA(12)) bus2 ();

    vga_scan_gen #(
        .pA(12), .CLK_DIV(1),
        .H_VIS(HV), .H_FP(HF), .H_SYN(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYN(VS), .V_BP(VB)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .vga (bus1)
    );

    vga_scan_gen #(
        .pA(12), .CLK_DIV(2),
        .H_VIS(HV), .H_FP(HF), .H_SYN(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYN(VS), .V_BP(VB)
    ) dut2 (
        .clk (clk),
        .rst (rst2),
        .vga (bus2)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_err = 0;
    bit    stop_run = 1'b0;
    int    t1 = 0;
    int    t2 = 0;
    outs_t q1[$];
    outs_t q2[$];
    vec_t  tbl[$];

    function automatic outs_t mk(int x, int y, bit pv, bit hs, bit vs, bit ir, int fc);
        outs_t o;
        o.x  = 12'(x);
        o.y  = 12'(y);
        o.pv = pv;
        o.hs = hs;
        o.vs = vs;
        o.ir = ir;
        o.fc = 8'(fc);
        return o;
    endfunction

    // Expected outputs t clocks after the first post-reset edge
    function automatic outs_t model(int t, int d);
        int n, h, v, fc;
        n  = t / d;
        h  = n % HT;
        v  = (n / HT) % VT;
        fc = (n >= VV * HT) ? (((n - VV * HT) / (HT * VT) + 1) % 256) : 0;
        return mk(h, v, (h < HV) && (v < VV),
                  !((h >= HV + HF) && (h < HV + HF + HS)),
                  !((v >= VV + VF) && (v < VV + VF + VS)),
                  ((t % d) == 0) && (h == 0) && (v == VV), fc);
    endfunction

    function automatic outs_t get(int which);
        if (which == 1)
            return mk(int'(bus1.pix_x), int'(bus1.pix_y), bus1.pix_v, bus1.hsync,
                      bus1.vsync, bus1.imgReturn, int'(bus1.frame_cnt));
        return mk(int'(bus2.pix_x), int'(bus2.pix_y), bus2.pix_v, bus2.hsync,
                  bus2.vsync, bus2.imgReturn, int'(bus2.frame_cnt));
    endfunction

    function automatic bit fld(outs_t o, int f);
        case (f)
            F_HS:    return o.hs;
            F_VS:    return o.vs;
            F_IR:    return o.ir;
            default: return o.pv;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_outs(input string nm, input int t, input outs_t a, input outs_t e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s t=%0d: got x=%0d y=%0d v=%0b hs=%0b vs=%0b ir=%0b fc=%0d want x=%0d y=%0d v=%0b hs=%0b vs=%0b ir=%0b fc=%0d",
                     nm, t, a.x, a.y, a.pv, a.hs, a.vs, a.ir, a.fc,
                     e.x, e.y, e.pv, e.hs, e.vs, e.ir, e.fc);
        end
        if (n_err >= 40) stop_run = 1'b1;
    endtask

    // One clock: push the expectation at the edge, pop and compare mid-cycle
    task automatic tick();
        outs_t e;
        @(posedge clk);
        q1.push_back(rst1 ? mk(0, 0, 0, 1, 1, 0, 0) : model(t1, 1));
        t1 = rst1 ? 0 : t1 + 1;
        q2.push_back(rst2 ? mk(0, 0, 0, 1, 1, 0, 0) : model(t2, 2));
        t2 = rst2 ? 0 : t2 + 1;
        @(negedge clk);
        e = q1.pop_front();
        cmp_outs("sb_div1", t1 - 1, get(1), e);
        e = q2.pop_front();
        cmp_outs("sb_div2", t2 - 1, get(2), e);
    endtask

    // Clocks until field f changes to lvl; -1 on timeout
    task automatic next_edge(input int which, input int f, input bit lvl, input int max, output int n);
        bit prev, cur;
        n    = 0;
        prev = fld(get(which), f);
        while (n < max) begin
            tick();
            n++;
            cur = fld(get(which), f);
            if (cur == lvl && prev != lvl) return;
            prev = cur;
        end
        n = -1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, w, r, k, pvc, vsc, vs_bad, extra, pulses;
        bit found;
        outs_t o;

        // Hand-computed outputs for the CLK_DIV=2 instance after release
        tbl.push_back('{0,   mk(0,  0, 1, 1, 1, 0, 0)});
        tbl.push_back('{2,   mk(1,  0, 1, 1, 1, 0, 0)});
        tbl.push_back('{15,  mk(7,  0, 1, 1, 1, 0, 0)});
        tbl.push_back('{16,  mk(8,  0, 0, 1, 1, 0, 0)});
        tbl.push_back('{20,  mk(10, 0, 0, 0, 1, 0, 0)});
        tbl.push_back('{25,  mk(12, 0, 0, 0, 1, 0, 0)});
        tbl.push_back('{26,  mk(13, 0, 0, 1, 1, 0, 0)});
        tbl.push_back('{28,  mk(0,  1, 1, 1, 1, 0, 0)});
        tbl.push_back('{112, mk(0,  4, 0, 1, 1, 1, 1)});
        tbl.push_back('{113, mk(0,  4, 0, 1, 1, 0, 1)});
        tbl.push_back('{140, mk(0,  5, 0, 1, 0, 0, 1)});
        tbl.push_back('{194, mk(13, 6, 0, 1, 0, 0, 1)});
        tbl.push_back('{196, mk(0,  7, 0, 1, 1, 0, 1)});
        tbl.push_back('{222, mk(13, 7, 0, 1, 1, 0, 1)});
        tbl.push_back('{224, mk(0,  0, 1, 1, 1, 0, 1)});

        // Reset held for three clocks
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hsync", int'(bus2.hsync), 1);
            check("rst_vsync", int'(bus2.vsync), 1);
            check("rst_imgReturn", int'(bus2.imgReturn), 0);
        end
        rst1 = 1'b0;
        rst2 = 1'b0;
        tick();
        check("pix_v_after_release", int'(bus2.pix_v), 1);

        // Vector table
        foreach (tbl[i]) begin
            k = 0;
            while (t2 <= tbl[i].t && k < 1000) begin
                tick();
                k++;
            end
            cmp_outs("table", tbl[i].t, get(2), tbl[i].e);
        end

        // Horizontal line, CLK_DIV=2
        next_edge(2, F_HS, 1'b0, 100, n);
        check("hsync_fall_x", int'(bus2.pix_x), HV + HF);
        next_edge(2, F_HS, 1'b1, 100, w);
        check("hsync_low_clks_div2", w, HS * 2);
        next_edge(2, F_HS, 1'b0, 100, r);
        check("line_clks_div2", w + r, HT * 2);

        // One frame from imgReturn to imgReturn, CLK_DIV=2
        next_edge(2, F_IR, 1'b1, 600, n);
        check("ir_found", int'(n > 0), 1);
        check("ir_pos_x", int'(bus2.pix_x), 0);
        check("ir_pos_y", int'(bus2.pix_y), VV);
        pvc = 0; vsc = 0; vs_bad = 0; extra = 0;
        for (int i = 1; i <= HT * VT * 2; i++) begin
            tick();
            o = get(2);
            if (o.pv) pvc++;
            if (!o.vs) begin
                vsc++;
                if (o.y != 12'(VV + VF) && o.y != 12'(VV + VF + 1)) vs_bad++;
            end
            if (o.ir && i < HT * VT * 2) extra++;
        end
        check("ir_period_div2", int'(bus2.imgReturn), 1);
        check("ir_extra_pulses", extra, 0);
        check("pix_v_clks_frame", pvc, HV * VV * 2);
        check("vsync_low_clks", vsc, VS * HT * 2);
        check("vsync_low_wrong_y", vs_bad, 0);
        tick();
        check("ir_width", int'(bus2.imgReturn), 0);

        // CLK_DIV=1 instance: line, sync width and frame period
        next_edge(1, F_HS, 1'b0, 100, n);
        next_edge(1, F_HS, 1'b1, 100, w);
        check("hsync_low_clks_div1", w, HS);
        next_edge(1, F_HS, 1'b0, 100, r);
        check("line_clks_div1", w + r, HT);
        next_edge(1, F_IR, 1'b1, 300, n);
        next_edge(1, F_IR, 1'b1, 300, n);
        check("frame_clks_div1", n, HT * VT);

        // Reset in the middle of a frame at (5,2)
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (bus2.pix_x == 12'd5 && bus2.pix_y == 12'd2) found = 1'b1;
        end
        check("mid_rst_pos_found", int'(found), 1);
        rst2 = 1'b1;
        tick();
        check("mid_rst_imgReturn", int'(bus2.imgReturn), 0);
        check("mid_rst_hsync", int'(bus2.hsync), 1);
        rst2 = 1'b0;
        n = 0;
        found = 1'b0;
        while (n < 400 && !found) begin
            tick();
            n++;
            if (n == 1) begin
                check("mid_rst_x0", int'(bus2.pix_x), 0);
                check("mid_rst_y0", int'(bus2.pix_y), 0);
                check("mid_rst_pv", int'(bus2.pix_v), 1);
            end
            if (bus2.imgReturn) found = 1'b1;
        end
        check("mid_rst_to_ir_clks", found ? n - 1 : -1, VV * HT * 2);
        check("mid_rst_fc", int'(bus2.frame_cnt), 1);

        // Frame corner (13,7) steps to (0,0)
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (bus2.pix_x == 12'(HT - 1) && bus2.pix_y == 12'(VT - 1)) found = 1'b1;
        end
        check("corner_found", int'(found), 1);
        tick();
        tick();
        check("corner_next_x", int'(bus2.pix_x), 0);
        check("corner_next_y", int'(bus2.pix_y), 0);
        check("corner_next_pv", int'(bus2.pix_v), 1);

        // frame_cnt wraps 255 -> 0
        pulses = 1;
        k = 0;
        while (pulses < 256 && k < 60000 && !stop_run) begin
            tick();
            k++;
            if (bus2.imgReturn) begin
                pulses++;
                if (pulses == 255) check("frame_cnt_255", int'(bus2.frame_cnt), 255);
                if (pulses == 256) check("frame_cnt_wrap", int'(bus2.frame_cnt), 0);
            end
        end
        check("frame_pulses", pulses, 256);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_scan_gen.md
# vga_scan_gen

Pixel-scan timing generator for the 640x480@60 VGA path. It divides the system clock down to a pixel tick and runs the horizontal and vertical scan counters. It drives `pix_x`/`pix_y`/`pix_v` into every level module and the active-low sync pins to the connector. It also issues the once-per-frame `imgReturn` strobe that the level logic uses to advance player motion and jump state during vertical blank.

## Interface
Parameters:
- `pA`, 12: width of the pixel coordinate outputs.
- `CLK_DIV`, 2: system clocks per pixel. Legal values are ≥1; 1 means a pixel on every clock.
- `H_VIS`, 640 / `H_FP`, 16 / `H_SYN`, 96 / `H_BP`, 48: horizontal visible width, front porch, sync width and back porch, in pixels.
- `V_VIS`, 480 / `V_FP`, 10 / `V_SYN`, 2 / `V_BP`, 33: vertical visible height, front porch, sync width and back porch, in lines.

Ports:
- `clk` in 1: system clock. This is the single clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `pix_x` out `pA`: current horizontal count. Valid as a coordinate only while `pix_v`=1.
- `pix_y` out `pA`: current vertical count.
- `pix_v` out 1: high while the current pixel is in the visible area.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `imgReturn` out 1: one-`clk` pulse at the start of vertical blank.
- `frame_cnt` out 8: frame counter, wraps from 255 to 0.

## Operation
Derived totals: H_TOT = H_VIS+H_FP+H_SYN+H_BP (800); V_TOT = V_VIS+V_FP+V_SYN+V_BP (525). Both totals fit in `pA` bits; a static elaboration assertion enforces this.

Pixel tick `pt`:
- The divider counts 0..CLK_DIV-1 and wraps.
- `pt` is high in the cycle where the divider equals CLK_DIV-1.
- With CLK_DIV=1, `pt` is held high constantly.

Scan counters `h`, `v` (advance only on `pt`):
- `h` counts 0..H_TOT-1 and wraps to 0.
- When `h` wraps, `v` increments; `v` counts 0..V_TOT-1 and wraps to 0.
- The simultaneous wrap of `h` and `v` at (H_TOT-1, V_TOT-1) goes to (0,0) in a single step.

Output decode, applied to the registered counters and then registered once:
- `pix_x`=h, `pix_y`=v.
- `pix_v` = (h<H_VIS) && (v<V_VIS).
- `hsync`=0 when H_VIS+H_FP ≤ h < H_VIS+H_FP+H_SYN, i.e. 656..751.
- `vsync`=0 when V_VIS+V_FP ≤ v < V_VIS+V_FP+V_SYN, i.e. 490..491.

`imgReturn`:
- Pulses high for exactly one `clk` in the cycle after the counters step to (h=0, v=V_VIS).
- It fires once per frame and never more than once per frame.
- `frame_cnt` increments in the same cycle as `imgReturn`.

## Timing
Reset values, in the cycle after `rst` is sampled high:
- Divider, `h`, `v`, `frame_cnt`: 0.
- `pix_x`, `pix_y`: 0.
- `pix_v`, `imgReturn`: 0.
- `hsync`, `vsync`: 1.

Latency:
- All outputs are registered and trail the counter state by one `clk`.
- After reset is released, `pix_v` is 1 from the first cycle onward, reflecting position (0,0).
- Each output is stable for CLK_DIV clocks per pixel; `imgReturn` is the only exception (one `clk` wide).

Reset mid-frame:
- Counters return to (0,0) on the next edge.
- No `imgReturn` is generated by the reset itself.
- Sync outputs go inactive (high) immediately.

`rst` takes priority over `pt` in the same cycle.

Frame period: H_TOT·V_TOT·CLK_DIV = 840 000 clocks at the default parameters.

## Structure
Shared package `vga_pkg`:
- Default 640x480 timing constants: H_VIS, H_FP, H_SYN, H_BP, V_VIS, V_FP, V_SYN, V_BP.
- Derived totals H_TOT and V_TOT.
- Pixel coordinate width `pA`.

The level modules import the same package for screen bounds.

Sub-module: `pix_tick_div`, parameterised by CLK_DIV, produces `pt`. The scan counters and output decode live in the top of the block.

## Test plan
- Reset behaviour: hold `rst` for 3 clocks, then release. Require `hsync`=`vsync`=1 and `imgReturn`=0 throughout reset, `pix_v`=1 from the first cycle after release, and `pix_x` reaching 1 after 2 clocks (CLK_DIV=2).
- Horizontal line: measure one line. Require `hsync` low for exactly 192 clocks starting when `pix_x`=656, `pix_v` high for 1280 clocks per visible line, and a line period of 1600 clocks.
- Vertical frame: measure one frame. Require `vsync` low exactly during `pix_y`=490..491 (3200 clocks), and `imgReturn` pulses exactly 840 000 clocks apart, each one `clk` wide, coinciding with `pix_x`=0, `pix_y`=480.
- Wrap boundary: run through the corner (799,524). Require the next pixel to be (0,0) with `pix_v`=1, and `frame_cnt` to wrap from 255 to 0 after 256 frames.
- Reset mid-frame: assert `rst` at `pix_y`=200, `pix_x`=300. Require the counters to restart at (0,0), no spurious `imgReturn`, and the next `imgReturn` exactly 480·1600 clocks after reset is released.
- CLK_DIV=1 variant: require a line period of 800 clocks, a frame period of 420 000 clocks, and a sync width of 96 clocks.
